axi_mem_slave: RTL and testbench
================================

// Module: axi_mem_slave
// PURPOSE
//  AXI4 memory-mapped slave RAM that terminates the cache's M_AXI_* master port.
//  - Accepts single and burst reads/writes and stores data in an internal word array.
//  - Acts as the backing memory / next level below the cache in system sim and FPGA builds.
//  - Write path (AW/W/B) and read path (AR/R) run as independent FSMs.
// PARAMETERS
//  AXI_ADDR_WIDTH  32  byte-address width
//  AXI_DATA_WIDTH  64  data width; supported values are 32 and 64
//  AXI_ID_WIDTH    4   transaction ID width
//  MEM_WORDS       1024  array depth in words; must be a power of 2
//  BASE_ADDR       32'h8000_0000  byte address of word 0
// PORTS
//  clk            in   1    clock, rising edge
//  rst_n          in   1    synchronous active-low reset
//  S_AXI_AWADDR/AWID/AWLEN/AWSIZE/AWBURST  in  AW,ID,8,3,2  write address channel
//  S_AXI_AWVALID  in   1    write address valid
//  S_AXI_AWREADY  out  1    write address ready
//  S_AXI_WDATA/WSTRB/WLAST  in  DW,DW/8,1  write data channel
//  S_AXI_WVALID   in   1    write data valid
//  S_AXI_WREADY   out  1    write data ready
//  S_AXI_BID/BRESP  out  ID,2  write response
//  S_AXI_BVALID   out  1    write response valid
//  S_AXI_BREADY   in   1    write response ready
//  S_AXI_ARADDR/ARID/ARLEN/ARSIZE/ARBURST  in  AW,ID,8,3,2  read address channel
//  S_AXI_ARVALID  in   1    read address valid
//  S_AXI_ARREADY  out  1    read address ready
//  S_AXI_RDATA/RID/RRESP/RLAST  out  DW,ID,2,1  read data channel
//  S_AXI_RVALID   out  1    read data valid
//  S_AXI_RREADY   in   1    read data ready
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 while rst_n=0.
//   - AWREADY/ARREADY go to 1 in the first cycle after release.
//   - Array contents are not reset.
//   - Reset mid-burst abandons the burst; no partial response is issued.
//  Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
//   - W_IDLE: AWREADY=1. On AWVALID, latch addr/ID/len/size/burst and go to W_DATA.
//   - W_DATA: WREADY=1. Each WVALID&&WREADY writes the byte lanes enabled by WSTRB.
//   - Beat count: beat k targets word (addr_k-BASE_ADDR)>>log2(DW/8) mod MEM_WORDS.
//   - W_DATA ends on the beat carrying WLAST.
//   - W_RESP: BVALID=1 and BID=latched AWID, held until BREADY; then back to W_IDLE.
//   - Beats are never written before AW is accepted.
//  Read FSM (R_IDLE -> R_DATA -> R_IDLE):
//   - R_IDLE: ARREADY=1. AR accepted at cycle N gives first RVALID at cycle N+1.
//   - R_DATA: RDATA/RID/RRESP/RLAST are registered and held stable while RVALID&&!RREADY.
//   - Beats are back-to-back when RREADY=1. RLAST=1 only on beat ARLEN.
//   - The FSM returns to R_IDLE after the last handshake; ARREADY=1 again in the following cycle.
//  Address arithmetic:
//   - INCR (2'b01): next = addr + (1<<SIZE), with the low SIZE bits of the start address cleared after beat 0.
//   - FIXED (2'b00): address is constant for every beat.
//   - Address wraps modulo 2^AXI_ADDR_WIDTH; the 4KB boundary is not checked.
//  Errors (RESP = SLVERR 2'b10):
//   - Triggers: any beat address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*DW/8), SIZE > log2(DW/8), or BURST=2'b11.
//   - Erroring write beats are dropped and the burst BRESP is SLVERR.
//   - Erroring read beats return RDATA=0 with per-beat RRESP=SLVERR.
//   - WLAST seen before beat AWLEN, or absent at beat AWLEN: BRESP=SLVERR, and the FSM still terminates on WLAST.
//   - Otherwise RESP=OKAY (2'b00).
//  Simultaneous events:
//   - A read and a write to the same word in the same cycle: the read returns the old data.
//   - AW and AR handshakes in the same cycle are both accepted.
// CONFIGURATION
//  AXI_MEM_WRAP_EN defined:
//   - WRAP bursts (2'b10) are supported. ARLEN/AWLEN must be 1, 3, 7 or 15, otherwise SLVERR.
//   - Wrap boundary = (LEN+1)<<SIZE; the address wraps to that aligned boundary.
//  AXI_MEM_WRAP_EN undefined:
//   - BURST=2'b10 is treated as an error. Every beat gets SLVERR; no array write, RDATA=0.
//   - All beats are still counted and the handshake completes normally.
// TESTING
//  1. Single write AWADDR=8000_0000, AWLEN=0, SIZE=3, WDATA=0123_4567_89AB_CDEF, WSTRB=FF
//     -> BRESP=00, BID=AWID. Read back of the same address -> RDATA=0123_4567_89AB_CDEF, RLAST=1, RRESP=00.
//  2. INCR write AWLEN=3 at 8000_0010, data 1..4; then ARLEN=3 read with RREADY toggling 1,0,1,0
//     -> RDATA 1,2,3,4 stable while stalled, RLAST only on beat 4.
//  3. Partial strobe: word = FFFF_FFFF_FFFF_FFFF, write 0 with WSTRB=0F -> readback FFFF_FFFF_0000_0000.
//  4. Out of range: ARADDR=0000_0000 -> RRESP=10, RDATA=0. Write to 0000_0000 -> BRESP=10 and array unchanged.
//  5. WLAST on beat 2 with AWLEN=3 -> BRESP=10 after beat 2; next AW accepted normally.
//     Reset asserted mid-read-burst -> RVALID=0 next cycle, ARREADY=1 after release.
//  6. WRAP ARLEN=3 at 8000_0018: macro on -> addresses 18,00,08,10 with OKAY;
//     macro off -> 4 beats with RRESP=10 and RDATA=0.

Source files
------------

// File: rtl/axi_mem_slave.sv
// AXI4 memory-mapped slave RAM with independent write (AW/W/B) and read (AR/R) FSMs.
// Optional WRAP burst support is enabled by defining AXI_MEM_WRAP_EN.
module axi_mem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_WORDS      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic [2:0]                  S_AXI_AWSIZE,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WLAST,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic [2:0]                  S_AXI_ARSIZE,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY
);
    localparam int BYTES    = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES = (AXI_ADDR_WIDTH+1)'(MEM_WORDS * BYTES);
    localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_MEM_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    function automatic logic beat_err(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                      input logic [1:0] burst, input logic [7:0] len);
        logic [AXI_ADDR_WIDTH:0] off;
        logic len_ok;
        off    = {1'b0, a - BASE_ADDR};
        len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (off >= MEM_BYTES) || (size > MAX_SIZE) || (burst == 2'b11) ||
               ((burst == 2'b10) && (!WRAP_EN || !len_ok));
    endfunction

    // WRAP keeps the bits above the (LEN+1)<<SIZE window and wraps the low bits inside it.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] a,
            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
        logic [AXI_ADDR_WIDTH-1:0] step, incr, wmask;
        step  = AXI_ADDR_WIDTH'(1) << size;
        incr  = (a & ~(step - 1'b1)) + step;
        wmask = ((AXI_ADDR_WIDTH'(len) + 1'b1) << size) - 1'b1;
        case (burst)
            2'b01:   return incr;
            2'b10:   return WRAP_EN ? ((a & ~wmask) | (incr & wmask)) : incr;
            default: return a;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> ADDR_LSB);
    endfunction

    // ---------------- write path ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t                  w_state_reg;
    logic                      awready_reg, wready_reg, bvalid_reg, werr_reg;
    logic [AXI_ID_WIDTH-1:0]   bid_reg;
    logic [1:0]                bresp_reg, awburst_reg;
    logic [2:0]                awsize_reg;
    logic [7:0]                awlen_reg, wcnt_reg;
    logic [AXI_ADDR_WIDTH-1:0] waddr_reg;
    logic                      w_beat_err, w_bad, mem_we;
    logic [IDX_W-1:0]          w_idx;

    assign w_beat_err = beat_err(waddr_reg, awsize_reg, awburst_reg, awlen_reg);
    assign w_bad      = w_beat_err || (S_AXI_WLAST != (wcnt_reg == awlen_reg));
    assign mem_we     = (w_state_reg == W_DATA) && wready_reg && S_AXI_WVALID && !w_beat_err;
    assign w_idx      = word_idx(waddr_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bid_reg     <= '0;
            bresp_reg   <= RESP_OKAY;
            werr_reg    <= 1'b0;
            wcnt_reg    <= '0;
            awlen_reg   <= '0;
            awsize_reg  <= '0;
            awburst_reg <= '0;
            waddr_reg   <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    awready_reg <= 1'b1;
                    if (S_AXI_AWVALID && awready_reg) begin
                        waddr_reg   <= S_AXI_AWADDR;
                        bid_reg     <= S_AXI_AWID;
                        awlen_reg   <= S_AXI_AWLEN;
                        awsize_reg  <= S_AXI_AWSIZE;
                        awburst_reg <= S_AXI_AWBURST;
                        wcnt_reg    <= '0;
                        werr_reg    <= 1'b0;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID && wready_reg) begin
                        if (S_AXI_WLAST) begin
                            wready_reg  <= 1'b0;
                            bvalid_reg  <= 1'b1;
                            bresp_reg   <= (werr_reg || w_bad) ? RESP_SLVERR : RESP_OKAY;
                            w_state_reg <= W_RESP;
                        end else begin
                            werr_reg  <= werr_reg || w_bad;
                            waddr_reg <= next_addr(waddr_reg, awsize_reg, awburst_reg, awlen_reg);
                            wcnt_reg  <= wcnt_reg + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t                  r_state_reg;
    logic                      arready_reg, rvalid_reg, rlast_reg;
    logic [AXI_ID_WIDTH-1:0]   rid_reg;
    logic [1:0]                rresp_reg, arburst_reg;
    logic [2:0]                arsize_reg;
    logic [7:0]                arlen_reg, rcnt_reg;
    logic [AXI_ADDR_WIDTH-1:0] raddr_reg;
    logic                      rd_load, rd_err, r_idle;
    logic [IDX_W-1:0]          rd_idx;

    // The beat being loaded comes from the AR inputs on acceptance, else from the running address.
    assign r_idle  = (r_state_reg == R_IDLE);
    assign rd_load = r_idle ? (S_AXI_ARVALID && arready_reg) : (S_AXI_RREADY && !rlast_reg);
    assign rd_err  = r_idle ? beat_err(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN)
                            : beat_err(raddr_reg, arsize_reg, arburst_reg, arlen_reg);
    assign rd_idx  = word_idx(r_idle ? S_AXI_ARADDR : raddr_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rid_reg     <= '0;
            rresp_reg   <= RESP_OKAY;
            rcnt_reg    <= '0;
            arlen_reg   <= '0;
            arsize_reg  <= '0;
            arburst_reg <= '0;
            raddr_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    arready_reg <= 1'b1;
                    if (S_AXI_ARVALID && arready_reg) begin
                        rid_reg     <= S_AXI_ARID;
                        arlen_reg   <= S_AXI_ARLEN;
                        arsize_reg  <= S_AXI_ARSIZE;
                        arburst_reg <= S_AXI_ARBURST;
                        raddr_reg   <= next_addr(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN);
                        rcnt_reg    <= '0;
                        rlast_reg   <= (S_AXI_ARLEN == 8'd0);
                        rresp_reg   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid_reg  <= 1'b1;
                        arready_reg <= 1'b0;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            arready_reg <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            raddr_reg <= next_addr(raddr_reg, arsize_reg, arburst_reg, arlen_reg);
                            rcnt_reg  <= rcnt_reg + 8'd1;
                            rlast_reg <= ((rcnt_reg + 8'd1) == arlen_reg);
                            rresp_reg <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // One byte-wide RAM per lane so WSTRB maps onto independent write enables.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_rd_reg;
            always_ff @(posedge clk) begin
                if (mem_we && S_AXI_WSTRB[gi])
                    lane_mem[w_idx] <= S_AXI_WDATA[gi*8 +: 8];
            end
            always_ff @(posedge clk) begin
                if (!rst_n)
                    lane_rd_reg <= 8'h00;
                else if (rd_load)
                    lane_rd_reg <= rd_err ? 8'h00 : lane_mem[rd_idx];
            end
            assign S_AXI_RDATA[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BID     = bid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RID     = rid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RLAST   = rlast_reg;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: expected B and R beats are queued as stimulus is issued.
module tb_axi_mem_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awid, arid, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;

    always #5 clk = ~clk;

    axi_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [63:0] wbuf [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
        rbeat_t e;
        e.data = d; e.resp = resp; e.last = last; e.id = id;
        rq.push_back(e);
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        logic hs = 1'b0;
        awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!hs && n < 50) begin
            hs = awready;
            @(negedge clk);
            n++;
        end
        awvalid = 1'b0;
        n_tests++;
        if (!hs) begin n_fail++; $display("FAIL aw_accept: awready=0 after %0d cycles, need 1", n); end
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        logic hs = 1'b0;
        araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!hs && n < 50) begin
            hs = arready;
            @(negedge clk);
            n++;
        end
        arvalid = 1'b0;
        n_tests++;
        if (!hs || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_latency: arready_seen=%0b rvalid=%0b one cycle after AR, need 1/1", hs, rvalid);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int last_beat, input logic [7:0] strb,
                            input logic [1:0] exp_resp);
        bexp_t b;
        int    n;
        logic  hs;
        b.resp = exp_resp; b.id = id;
        bq.push_back(b);
        do_aw(addr, id, len, 3'd3, burst);
        for (int k = 0; k <= last_beat; k++) begin
            wdata = wbuf[k]; wstrb = strb; wlast = (k == last_beat); wvalid = 1'b1;
            n = 0; hs = 1'b0;
            while (!hs && n < 50) begin
                hs = wready;
                @(negedge clk);
                n++;
            end
            n_tests++;
            if (!hs) begin n_fail++; $display("FAIL w_beat%0d: wready=0, need 1", k); end
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        b = bq.pop_front();
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== b.resp || bid !== b.id) begin
            n_fail++;
            $display("FAIL bresp @%h: bvalid=%0b bresp=%b bid=%h, need 1 %b %h", addr, bvalid, bresp, bid, b.resp, b.id);
        end
        @(negedge clk);
        bready = 1'b0;
        n_tests++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_done: bvalid=%0b awready=%0b, need 0 1", bvalid, awready);
        end
        $display("[TB] write @%h len=%0d burst=%b -> bresp=%b", addr, len, burst, bresp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [15:0] pat);
        rbeat_t e;
        int     cyc = 0;
        do_ar(addr, id, len, size, burst);
        while (rq.size() > 0 && cyc < 200) begin
            rready = pat[cyc % 16];
            if (rvalid) begin
                e = rq[0];
                n_tests++;
                if (rdata !== e.data || rresp !== e.resp || rlast !== e.last || rid !== e.id) begin
                    n_fail++;
                    $display("FAIL rbeat @%h cyc%0d: data=%h resp=%b last=%0b id=%h, need %h %b %0b %h",
                             addr, cyc, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                end
                if (rready) void'(rq.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        n_tests++;
        if (rq.size() != 0 || arready !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL r_done @%h: pending=%0d arready=%0b rvalid=%0b, need 0 1 0", addr, rq.size(), arready, rvalid);
            rq.delete();
        end
        $display("[TB] read  @%h len=%0d burst=%b done after %0d cycles", addr, len, burst, cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 || rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: aw/ar/w/b/r/last=%b rdata=%h, need 000000 0",
                     {awready, arready, wready, bvalid, rvalid, rlast}, rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: awready=%0b arready=%0b, need 1 1", awready, arready);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        wbuf[0] = 64'h0123_4567_89AB_CDEF;
        do_write(32'h8000_0000, 4'h5, 8'd0, 2'b01, 0, 8'hFF, 2'b00);
        push_r(64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 4'h3);
        do_read(32'h8000_0000, 4'h3, 8'd0, 3'd3, 2'b01, 16'hFFFF);
    endtask

    task automatic test_incr_stall();
        for (int k = 0; k < 4; k++) wbuf[k] = 64'(k + 1);
        do_write(32'h8000_0010, 4'h1, 8'd3, 2'b01, 3, 8'hFF, 2'b00);
        for (int k = 0; k < 4; k++) push_r(64'(k + 1), 2'b00, k == 3, 4'h7);
        do_read(32'h8000_0010, 4'h7, 8'd3, 3'd3, 2'b01, 16'h5555);
    endtask

    task automatic test_strobe();
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(32'h8000_0100, 4'h2, 8'd0, 2'b01, 0, 8'hFF, 2'b00);
        wbuf[0] = 64'h0;
        do_write(32'h8000_0100, 4'h2, 8'd0, 2'b01, 0, 8'h0F, 2'b00);
        push_r(64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'h2);
        do_read(32'h8000_0100, 4'h2, 8'd0, 3'd3, 2'b01, 16'hFFFF);
    endtask

    task automatic test_errors();
        push_r(64'h0, 2'b10, 1'b1, 4'h4);
        do_read(32'h0000_0000, 4'h4, 8'd0, 3'd3, 2'b01, 16'hFFFF);
        wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        do_write(32'h0000_0000, 4'h6, 8'd0, 2'b01, 0, 8'hFF, 2'b10);
        push_r(64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 4'h4);
        do_read(32'h8000_0000, 4'h4, 8'd0, 3'd3, 2'b01, 16'hFFFF);
        push_r(64'h0, 2'b10, 1'b1, 4'h9);
        do_read(32'h8000_0000, 4'h9, 8'd0, 3'd4, 2'b01, 16'hFFFF);
        // Last in-range word, then the first word past the end of the array.
        wbuf[0] = 64'h1111_2222_3333_4444;
        do_write(32'h8000_1FF8, 4'hA, 8'd0, 2'b01, 0, 8'hFF, 2'b00);
        push_r(64'h1111_2222_3333_4444, 2'b00, 1'b0, 4'hA);
        push_r(64'h0, 2'b10, 1'b1, 4'hA);
        do_read(32'h8000_1FF8, 4'hA, 8'd1, 3'd3, 2'b01, 16'hFFFF);
    endtask

    task automatic test_wlast();
        for (int k = 0; k < 4; k++) wbuf[k] = 64'h50 + 64'(k);
        do_write(32'h8000_0200, 4'hB, 8'd3, 2'b01, 1, 8'hFF, 2'b10);
        do_write(32'h8000_0220, 4'hC, 8'd1, 2'b01, 2, 8'hFF, 2'b10);
        wbuf[0] = 64'hCAFE_F00D_0000_0001;
        do_write(32'h8000_0240, 4'hD, 8'd0, 2'b01, 0, 8'hFF, 2'b00);
        push_r(64'hCAFE_F00D_0000_0001, 2'b00, 1'b1, 4'hD);
        do_read(32'h8000_0240, 4'hD, 8'd0, 3'd3, 2'b01, 16'hFFFF);
    endtask

    task automatic test_fixed();
        wbuf[0] = 64'h11; wbuf[1] = 64'h22;
        do_write(32'h8000_0300, 4'h3, 8'd1, 2'b00, 1, 8'hFF, 2'b00);
        push_r(64'h22, 2'b00, 1'b0, 4'h3);
        push_r(64'h22, 2'b00, 1'b1, 4'h3);
        do_read(32'h8000_0300, 4'h3, 8'd1, 3'd3, 2'b00, 16'hFFFF);
    endtask

    task automatic test_reset_mid_read();
        do_ar(32'h8000_0010, 4'h1, 8'd3, 3'd3, 2'b01);
        rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rready = 1'b0;
        n_tests++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: rvalid=%0b arready=%0b, need 0 0", rvalid, arready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: arready=%0b rvalid=%0b, need 1 0", arready, rvalid);
        end
        $display("[TB] reset during read burst checked");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) wbuf[k] = 64'hA0 + 64'(k);
        do_write(32'h8000_0000, 4'h2, 8'd3, 2'b01, 3, 8'hFF, 2'b00);
`ifdef AXI_MEM_WRAP_EN
        push_r(64'hA3, 2'b00, 1'b0, 4'h6);
        push_r(64'hA0, 2'b00, 1'b0, 4'h6);
        push_r(64'hA1, 2'b00, 1'b0, 4'h6);
        push_r(64'hA2, 2'b00, 1'b1, 4'h6);
`else
        for (int k = 0; k < 4; k++) push_r(64'h0, 2'b10, k == 3, 4'h6);
`endif
        do_read(32'h8000_0018, 4'h6, 8'd3, 3'd3, 2'b10, 16'hFFFF);
    endtask

    initial begin
        awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_incr_stall();
        test_strobe();
        test_errors();
        test_wlast();
        test_fixed();
        test_reset_mid_read();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "timeout");
    end
endmodule
